// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel deframer.
package s2p_pkg;

   localparam int S2P_WIDTH_DEF = 16;

   typedef enum logic {
      S2P_IDLE  = 1'b0,
      S2P_SHIFT = 1'b1
   } s2p_state_t;

   // Smallest r with 2**r >= n; sizes the bit counter and FIFO pointers.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/s2p_deframer_if.sv
// Valid/ready word stream leaving the deframer.
interface s2p_deframer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/s2p_fifo.sv
// Sync FIFO, registered pointers, no bypass: a push is visible the cycle after.
// A push while full is taken only when a pop happens in the same cycle.
module s2p_fifo
   import s2p_pkg::*;
#(
   parameter int WIDTH      = S2P_WIDTH_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/s2p_deframer.sv
// Deframes fs-led MSB-first serial words into a FIFO; m_valid one cycle after the last bit.
// Backpressure: full FIFO drops new words (sticky ovf). S2P_ERR_CNT_EN adds err_cnt.
module s2p_deframer
   import s2p_pkg::*;
#(
   parameter int WIDTH      = S2P_WIDTH_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sdin,
   input  logic           fs_in,
   s2p_deframer_if.master m,
   output logic           frame_err,
   output logic           ovf
`ifdef S2P_ERR_CNT_EN
   ,
   output logic [7:0]     err_cnt
`endif
);

   localparam int CW = clog2(WIDTH);
   localparam logic [0:0]    ST_IDLE  = S2P_IDLE;
   localparam logic [0:0]    ST_SHIFT = S2P_SHIFT;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [0:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] word_nxt;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_head;

   assign word_nxt  = {shreg, sdin};
   assign push      = !rst && (state == ST_SHIFT) && !fs_in && (bit_cnt == CNT_LAST);
   assign pop       = m.m_valid && m.m_ready;
   assign frame_err = !rst && (state == ST_SHIFT) && fs_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fs_in) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
               end
            end
            default: begin
               // A sync inside a frame restarts it; the fs cycle carries no data bit.
               if (fs_in) begin
                  bit_cnt <= '0;
                  shreg   <= '0;
               end else begin
                  shreg <= word_nxt[WIDTH-2:0];
                  if (bit_cnt == CNT_LAST) begin
                     state   <= ST_IDLE;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_ONE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         ovf <= 1'b1;
      end
   end

`ifdef S2P_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (frame_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

   s2p_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (word_nxt),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign m.m_valid = !fifo_empty;
   assign m.m_data  = fifo_head;

endmodule

// File: tb/tb_s2p_deframer.sv
// Directed bench for s2p_deframer: queue-based FIFO model checked every cycle, plus literal word lists.
module tb_s2p_deframer;

   localparam int W = 16;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst;
   logic sdin;
   logic fs_in;
   logic frame_err;
   logic ovf;
`ifdef S2P_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   s2p_deframer_if #(.WIDTH(W)) bus ();

   s2p_deframer #(
      .WIDTH      (W),
      .FIFO_DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sdin      (sdin),
      .fs_in     (fs_in),
      .m         (bus),
      .frame_err (frame_err),
      .ovf       (ovf)
`ifdef S2P_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: expected FIFO contents, sticky overflow, expected frame_err this cycle.
   logic [W-1:0] mq[$];
   bit           m_ovf = 1'b0;
   bit           exp_ferr = 1'b0;
   bit           chk_en = 1'b0;

   logic [W-1:0] got_q[$];
   int           ferr_seen = 0;
   int           valid_cycles = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_valid", 32'(bus.m_valid), 32'(mq.size() > 0));
         chk("m_data", 32'(bus.m_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("frame_err", 32'(frame_err), 32'(exp_ferr));
         if (bus.m_valid && bus.m_ready && !rst) got_q.push_back(bus.m_data);
         if (bus.m_valid) valid_cycles++;
         if (frame_err) ferr_seen++;
      end
   end

   // One clock cycle: drive inputs, let the edge consume them, advance the model.
   task automatic tick(input bit fs, input bit sd, input bit rdy, input bit r,
                       input bit push, input logic [W-1:0] w, input bit ferr);
      fs_in       = fs;
      sdin        = sd;
      bus.m_ready = rdy;
      rst         = r;
      exp_ferr    = ferr && !r;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < D) mq.push_back(w);
            else m_ovf = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int k = 0; k < n; k++) tick(1'b0, 1'($urandom_range(1, 0)), rdy, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic send_frame(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input bit ferr);
      tick(1'b1, 1'b0, rdy, 1'b0, 1'b0, '0, ferr);
      for (int i = W - 1; i >= 0; i--)
         tick(1'b0, w[i], (i == 0) ? rdy_last : rdy, 1'b0, (i == 0), w, 1'b0);
   endtask

   task automatic expect_words(input string nm, input int n,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      logic [W-1:0] e [3];
      e[0] = a; e[1] = b; e[2] = c;
      chk({nm, "_count"}, 32'(got_q.size()), 32'(n));
      for (int k = 0; k < n && k < got_q.size(); k++) chk({nm, "_word"}, 32'(got_q[k]), 32'(e[k]));
      got_q.delete();
   endtask

   initial begin
      // Reset held for 10 cycles
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk_en = 1'b1;
      for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      // 1: single word, one-cycle latency, single-cycle valid
      valid_cycles = 0;
      send_frame(16'h1111, 1'b1, 1'b1, 1'b0);
      chk("t1_latency", 32'(bus.m_valid), 32'd1);
      idle(3, 1'b1);
      expect_words("t1", 1, 16'h1111, 16'h0000, 16'h0000);
      chk("t1_valid_cycles", 32'(valid_cycles), 32'd1);

      // 2: back-to-back frames
      ferr_seen = 0;
      send_frame(16'hA5C3, 1'b1, 1'b1, 1'b0);
      send_frame(16'h0F0F, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      expect_words("t2", 2, 16'hA5C3, 16'h0F0F, 16'h0000);
      chk("t2_frame_err", 32'(ferr_seen), 32'd0);
      chk("t2_ovf", 32'(ovf), 32'd0);

      // 3: overflow with consumer stalled
      send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
      send_frame(16'h5678, 1'b0, 1'b0, 1'b0);
      send_frame(16'h9ABC, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("t3_ovf", 32'(ovf), 32'd1);
      chk("t3_head", 32'(bus.m_data), 32'h1234);
      idle(4, 1'b1);
      expect_words("t3", 2, 16'h1234, 16'h5678, 16'h0000);

      // 4: mid-frame sync aborts a partial word
      ferr_seen = 0;
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      send_frame(16'hBEEF, 1'b1, 1'b1, 1'b1);
      idle(3, 1'b1);
      expect_words("t4", 1, 16'hBEEF, 16'h0000, 16'h0000);
      chk("t4_frame_err_pulses", 32'(ferr_seen), 32'd1);
`ifdef S2P_ERR_CNT_EN
      chk("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif

      // 5: reset discards a partial frame and clears sticky ovf
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk("t5_rst_ovf", 32'(ovf), 32'd0);
      chk("t5_rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("t5_rst_m_data", 32'(bus.m_data), 32'd0);
      got_q.delete();
      idle(2, 1'b1);
      send_frame(16'h0001, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      expect_words("t5", 1, 16'h0001, 16'h0000, 16'h0000);
      chk("t5_ovf", 32'(ovf), 32'd0);

      // 6: push into a full FIFO on the same cycle as a pop
      send_frame(16'h1357, 1'b0, 1'b0, 1'b0);
      send_frame(16'h2468, 1'b0, 1'b0, 1'b0);
      send_frame(16'h00FF, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);
      expect_words("t6", 3, 16'h1357, 16'h2468, 16'h00FF);
      chk("t6_ovf", 32'(ovf), 32'd0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
